// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin N-channel arbiter onto one shared DDR host port.
// Defining DDR_ARB_MAXHOLD_EN adds MAX_HOLD-cycle preemption of a long-held owner.
module ddr_arbiter #(
    parameter int NCH = 4,
    parameter int AW  = 29,
    parameter int DW  = 64,
    parameter int BW  = 8,
    parameter int PW  = 12
`ifdef DDR_ARB_MAXHOLD_EN
    ,
    parameter int MAX_HOLD = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NCH-1:0]          ch_acquire,
    input  logic [NCH*AW-1:0]       ch_addr,
    input  logic [NCH*DW-1:0]       ch_wdata,
    input  logic [NCH-1:0]          ch_read,
    input  logic [NCH-1:0]          ch_write,
    input  logic [NCH*BW-1:0]       ch_burstcnt,
    input  logic [NCH*DW/8-1:0]     ch_byteenable,
    output logic [NCH-1:0]          ch_busy,
    output logic [DW-1:0]           ch_rdata,
    output logic [NCH-1:0]          ch_rdata_ready,
    output logic                    x_acquire,
    output logic [AW-1:0]           x_addr,
    output logic [DW-1:0]           x_wdata,
    output logic                    x_read,
    output logic                    x_write,
    output logic [BW-1:0]           x_burstcnt,
    output logic [DW/8-1:0]         x_byteenable,
    input  logic                    x_busy,
    input  logic [DW-1:0]           x_rdata,
    input  logic                    x_rdata_ready,
    output logic [$clog2(NCH)-1:0]  grant
);
    localparam int GW  = $clog2(NCH);
    localparam int BEW = DW / 8;
    localparam int SW  = ((PW > BW) ? PW : BW) + 2;
    localparam logic [SW-1:0] PMAX = SW'((1 << PW) - 1);

    typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   owner_q, owner_d;
    logic [GW-1:0]   last_q, last_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic [BW-1:0]   wrem_q, wrem_d;

    logic [GW-1:0]   pick, cand;
    logic            found;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BW-1:0]   sel_bc, bc;
    logic [BEW-1:0]  sel_be;
    logic            sel_read, sel_write, sel_acq;
    logic            acc_rd, acc_wr;
    logic [SW-1:0]   pend_sum;

    // Owner's command fields; the host port always reflects the current owner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_bc    = '0;
        sel_be    = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        sel_acq   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (owner_q == GW'(i)) begin
                sel_addr  = ch_addr[i*AW +: AW];
                sel_wdata = ch_wdata[i*DW +: DW];
                sel_bc    = ch_burstcnt[i*BW +: BW];
                sel_be    = ch_byteenable[i*BEW +: BEW];
                sel_read  = ch_read[i];
                sel_write = ch_write[i];
                sel_acq   = ch_acquire[i];
            end
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = GW'((int'(last_q) + k) % NCH);
            if (!found && ch_acquire[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

`ifdef DDR_ARB_MAXHOLD_EN
    logic [15:0] hold_q, hold_d;
    logic        others;

    always_comb begin
        others = |(ch_acquire & ~(NCH'(1) << owner_q));
        hold_d = hold_q;
        if (state_q != OWNED)
            hold_d = '0;
        else if (others && hold_q != '1)
            hold_d = hold_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hold_q <= '0;
        else          hold_q <= hold_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        x_read  = 1'b0;
        x_write = 1'b0;
        ch_busy = '1;
        case (state_q)
            IDLE: begin
                if (|ch_acquire) begin
                    state_d = OWNED;
                    owner_d = pick;
                end
            end
            OWNED: begin
                x_read           = sel_read & sel_acq;
                x_write          = sel_write & sel_acq;
                ch_busy[owner_q] = x_busy;
                if (!sel_acq) begin
                    if (pend_q == '0 && wrem_q == '0) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end
`ifdef DDR_ARB_MAXHOLD_EN
                else if (hold_q >= 16'(MAX_HOLD)) begin
                    state_d = DRAIN;
                end
`endif
            end
            DRAIN: begin
                // Only an unfinished write burst keeps the owner talking to the host.
                if (wrem_q != '0) begin
                    x_write          = sel_write;
                    ch_busy[owner_q] = x_busy;
                end
                if (pend_q == '0 && wrem_q == '0) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bc       = (sel_bc == '0) ? BW'(1) : sel_bc;
        acc_rd   = x_read & ~x_busy;
        acc_wr   = x_write & ~x_busy;
        pend_sum = SW'(pend_q) + (acc_rd ? SW'(bc) : SW'(0));
        if (x_rdata_ready && pend_sum != '0)
            pend_sum = pend_sum - SW'(1);
        pend_d = (pend_sum > PMAX) ? '1 : pend_sum[PW-1:0];
        wrem_d = wrem_q;
        if (acc_wr)
            wrem_d = (wrem_q == '0) ? bc - BW'(1) : wrem_q - BW'(1);
    end

    always_comb begin
        ch_rdata_ready = '0;
        for (int i = 0; i < NCH; i++)
            ch_rdata_ready[i] = x_rdata_ready & (owner_q == GW'(i)) & (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= GW'(NCH - 1);
            pend_q  <= '0;
            wrem_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            wrem_q  <= wrem_d;
        end
    end

    assign x_acquire    = (|ch_acquire) | (state_q == DRAIN);
    assign ch_rdata     = x_rdata;
    assign x_addr       = sel_addr;
    assign x_wdata      = sel_wdata;
    assign x_burstcnt   = sel_bc;
    assign x_byteenable = sel_be;
    assign grant        = owner_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed-vector bench for ddr_arbiter: a cycle table plus hand-written burst/drain sequences.
module tb_ddr_arbiter;
    localparam int NCH = 4;
    localparam int AW  = 29;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int PW  = 12;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NCH-1:0]      ch_acquire, ch_read, ch_write;
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*DW-1:0]   ch_wdata;
    logic [NCH*BW-1:0]   ch_burstcnt;
    logic [NCH*DW/8-1:0] ch_byteenable;
    logic [NCH-1:0]      ch_busy, ch_rdata_ready;
    logic [DW-1:0]       ch_rdata, x_wdata, x_rdata;
    logic                x_acquire, x_read, x_write, x_busy, x_rdata_ready;
    logic [AW-1:0]       x_addr;
    logic [BW-1:0]       x_burstcnt;
    logic [DW/8-1:0]     x_byteenable;
    logic [1:0]          grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .BW(BW), .PW(PW)
`ifdef DDR_ARB_MAXHOLD_EN
        , .MAX_HOLD(16)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .ch_acquire(ch_acquire), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_read(ch_read), .ch_write(ch_write), .ch_burstcnt(ch_burstcnt),
        .ch_byteenable(ch_byteenable), .ch_busy(ch_busy), .ch_rdata(ch_rdata),
        .ch_rdata_ready(ch_rdata_ready), .x_acquire(x_acquire), .x_addr(x_addr),
        .x_wdata(x_wdata), .x_read(x_read), .x_write(x_write),
        .x_burstcnt(x_burstcnt), .x_byteenable(x_byteenable), .x_busy(x_busy),
        .x_rdata(x_rdata), .x_rdata_ready(x_rdata_ready), .grant(grant)
    );

    typedef struct packed {
        logic [3:0] acq, rd, wr;
        logic       xb, rdv;
        logic [3:0] busy, rdy;
        logic [1:0] g;
        logic       xrd, xwr, xacq;
    } vec_t;

    vec_t tbl[22];

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h0012_3400 + i * 32'h10);
    endfunction
    function automatic logic [DW-1:0] wdata_of(input int i);
        return {32'hCAFE_0000 + 32'(i), 32'h0BAD_F00D ^ 32'(i)};
    endfunction
    function automatic logic [DW/8-1:0] be_of(input int i);
        return 8'h80 | 8'(1 << i);
    endfunction

    task automatic drive(input logic [3:0] acq, rd, wr, input logic xb, rdv, input logic [7:0] bc);
        ch_acquire    = acq;
        ch_read       = rd;
        ch_write      = wr;
        x_busy        = xb;
        x_rdata_ready = rdv;
        ch_burstcnt   = {NCH{bc}};
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 8'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW]         = addr_of(i);
            ch_wdata[i*DW +: DW]        = wdata_of(i);
            ch_byteenable[i*DW/8 +: DW/8] = be_of(i);
        end
        x_rdata = 64'hDEAD_BEEF_0123_4567;

        //            acq      rd       wr       xb   rdv  | busy     rdy      g     xrd  xwr  xacq
        tbl[0]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{4'b0110, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b1101, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1101, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b1011, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 4'b1011, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1011, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0};
        for (int r = 12; r <= 17; r++)
            tbl[r] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1};
        tbl[21] = '{4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1};

        // Reset values while every channel is requesting a transfer
        drive(4'b0000, 4'b1111, 4'b1111, 1'b0, 1'b1, 8'd1);
        #3;
        chk("rst_busy", ch_busy, 4'b1111);
        chk("rst_rdy", ch_rdata_ready, 4'b0000);
        chk("rst_xrd", x_read, 1'b0);
        chk("rst_xwr", x_write, 1'b0);
        chk("rst_xacq", x_acquire, 1'b0);
        chk("rst_grant", grant, 2'd0);
        chk("rdata_bcast", ch_rdata, 64'hDEAD_BEEF_0123_4567);
        do_reset();

        // Table: rotation from last=3, read drain, accept+beat in one cycle, stray beat in IDLE
        for (int v = 0; v < 22; v++) begin
            drive(tbl[v].acq, tbl[v].rd, tbl[v].wr, tbl[v].xb, tbl[v].rdv, 8'd4);
            #1;
            chk($sformatf("v%0d_busy", v), ch_busy, tbl[v].busy);
            chk($sformatf("v%0d_rdy", v), ch_rdata_ready, tbl[v].rdy);
            chk($sformatf("v%0d_grant", v), grant, tbl[v].g);
            chk($sformatf("v%0d_xrd", v), x_read, tbl[v].xrd);
            chk($sformatf("v%0d_xwr", v), x_write, tbl[v].xwr);
            chk($sformatf("v%0d_xacq", v), x_acquire, tbl[v].xacq);
            step();
        end

        // Asynchronous reset while ch2 owns with 5 beats outstanding
        do_reset();
        drive(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd5);
        step();
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd5);
        #1;
        chk("mr_xrd_pre", x_read, 1'b1);
        chk("mr_grant_pre", grant, 2'd2);
        step();
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_busy", ch_busy, 4'b1111);
        chk("mr_xrd", x_read, 1'b0);
        chk("mr_grant", grant, 2'd0);
        chk("mr_rdy", ch_rdata_ready, 4'b0000);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd5);
        reset_n = 1'b1;
        #1;
        chk("mr_rdy_rel", ch_rdata_ready, 4'b0000);
        chk("mr_xacq_rel", x_acquire, 1'b0);
        step();
        chk("mr_rdy_next", ch_rdata_ready, 4'b0000);

        // Ch1 write burst of 4, acquire dropped after the first beat
        do_reset();
        drive(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd4);
        step();
        drive(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd4);
        #1;
        chk("wr_xwr_b1", x_write, 1'b1);
        chk("wr_addr", x_addr, addr_of(1));
        chk("wr_wdata", x_wdata, wdata_of(1));
        chk("wr_bc", x_burstcnt, 8'd4);
        chk("wr_be", x_byteenable, be_of(1));
        chk("wr_busy_b1", ch_busy, 4'b1101);
        step();
        drive(4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd4);
        #1;
        chk("wr_drop_gated", x_write, 1'b0);
        step();
        chk("wr_xwr_b2", x_write, 1'b1);
        chk("wr_busy_b2", ch_busy, 4'b1101);
        step();
        drive(4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 8'd4);
        #1;
        chk("wr_busy_stall", ch_busy, 4'b1111);
        step();
        drive(4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd4);
        #1;
        chk("wr_xwr_b3", x_write, 1'b1);
        step();
        chk("wr_xwr_b4", x_write, 1'b1);
        step();
        chk("wr_done_xwr", x_write, 1'b0);
        chk("wr_done_busy", ch_busy, 4'b1111);
        chk("wr_done_xacq", x_acquire, 1'b1);
        step();
        chk("wr_idle_xacq", x_acquire, 1'b0);

        // Ch0 read burst of 8 while ch3 waits; hand-over only after the last beat
        do_reset();
        drive(4'b1001, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd8);
        step();
        drive(4'b1001, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd8);
        #1;
        chk("rb_xrd", x_read, 1'b1);
        chk("rb_grant0", grant, 2'd0);
        step();
        drive(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd8);
        step();
        for (int b = 0; b < 8; b++) begin
            drive(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd8);
            #1;
            chk($sformatf("rb_rdy%0d", b), ch_rdata_ready, 4'b0001);
            chk($sformatf("rb_grant%0d", b), grant, 2'd0);
            step();
        end
        drive(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd8);
        #1;
        chk("rb_drain_end", grant, 2'd0);
        step();
        chk("rb_idle_busy", ch_busy, 4'b1111);
        step();
        chk("rb_grant3", grant, 2'd3);
        chk("rb_busy3", ch_busy, 4'b0111);

        // Burst count 0 counts as a single beat
        do_reset();
        drive(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
        step();
        drive(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd0);
        step();
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd0);
        #1;
        chk("b0_rdy", ch_rdata_ready, 4'b0001);
        step();
        drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0);
        #1;
        chk("b0_drain_xacq", x_acquire, 1'b1);
        step();
        chk("b0_idle_xacq", x_acquire, 1'b0);

`ifdef DDR_ARB_MAXHOLD_EN
        // Ch0 holds while ch2 waits: preempted after MAX_HOLD cycles
        begin
            int cyc;
            logic saw_busy0;
            do_reset();
            drive(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1);
            step();
            drive(4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1);
            saw_busy0 = 1'b0;
            for (cyc = 0; cyc < 80 && grant != 2'd2; cyc++) begin
                step();
                if (grant == 2'd0 && ch_busy[0]) saw_busy0 = 1'b1;
            end
            chk("mh_grant2", grant, 2'd2);
            chk("mh_busy0", saw_busy0, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
